// File: rtl/mem_wb_multi.sv
// mem_wb_multi: MEM->WB pipeline register for a multi-issue core.
// Carries NUM_CH register-write channels. Each edge does one of four things,
// in priority order: flush, bubble, advance or hold.
// On advance, a channel's write is dropped when it targets x0, or when a
// younger channel writes the same register in the same cycle.
// Optional feature macro: MEM_WB_PERF_CNT_EN enables the retire and bubble
// counters. When the macro is undefined, both count ports are tied to 0.
module mem_wb_multi #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [STALL_W-1:0]         stall_in,
    input  logic                       flush_in,
    input  logic [NUM_CH-1:0]          valid_in,
    input  logic [NUM_CH-1:0]          rdE_in,
    input  logic [NUM_CH*IDX_W-1:0]    rdIdx_in,
    input  logic [NUM_CH*DATA_W-1:0]   rdData_in,
    output logic [NUM_CH-1:0]          rdE_out,
    output logic [NUM_CH*IDX_W-1:0]    rdIdx_out,
    output logic [NUM_CH*DATA_W-1:0]   rdData_out,
    output logic [CNT_W-1:0]           retire_cnt_out,
    output logic [CNT_W-1:0]           bubble_cnt_out
);

    // WB's stall bit must exist above this stage's bit.
    if (STAGE > STALL_W - 2) begin : g_bad_stage
        $error("mem_wb_multi: STAGE must be <= STALL_W-2");
    end

    logic                      stall_me;
    logic                      bubble;
    logic                      advance;
    logic [NUM_CH-1:0]         keep;
    logic [NUM_CH-1:0]         rdE_d,    rdE_q;
    logic [NUM_CH*IDX_W-1:0]   rdIdx_d,  rdIdx_q;
    logic [NUM_CH*DATA_W-1:0]  rdData_d, rdData_q;

    assign stall_me = stall_in[STAGE];
    assign bubble   = stall_me && !stall_in[STAGE+1];
    assign advance  = !stall_me;

    // Decide per channel whether its write survives x0 and same-cycle WAW filtering.
    always_comb begin
        keep = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            keep[c] = rdE_in[c] && (rdIdx_in[c*IDX_W +: IDX_W] != '0);
            for (int y = c + 1; y < NUM_CH; y++) begin
                if (rdE_in[y] && (rdIdx_in[y*IDX_W +: IDX_W] == rdIdx_in[c*IDX_W +: IDX_W])) begin
                    keep[c] = 1'b0;
                end
            end
        end
    end

    // Next state of the write-back payload: flush/bubble zero it, advance loads, else hold.
    always_comb begin
        rdE_d    = rdE_q;
        rdIdx_d  = rdIdx_q;
        rdData_d = rdData_q;
        if (flush_in || bubble) begin
            rdE_d    = '0;
            rdIdx_d  = '0;
            rdData_d = '0;
        end else if (advance) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rdE_d[c]                   = keep[c];
                rdIdx_d[c*IDX_W +: IDX_W]  = keep[c] ? rdIdx_in[c*IDX_W +: IDX_W] : '0;
                rdData_d[c*DATA_W +: DATA_W] = keep[c] ? rdData_in[c*DATA_W +: DATA_W] : '0;
            end
        end
    end

    // Payload register; reset clears it immediately.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rdE_q    <= '0;
            rdIdx_q  <= '0;
            rdData_q <= '0;
        end else begin
            rdE_q    <= rdE_d;
            rdIdx_q  <= rdIdx_d;
            rdData_q <= rdData_d;
        end
    end

    assign rdE_out    = rdE_q;
    assign rdIdx_out  = rdIdx_q;
    assign rdData_out = rdData_q;

`ifdef MEM_WB_PERF_CNT_EN
    logic [CNT_W-1:0] pop;
    logic [CNT_W-1:0] retire_d, retire_q;
    logic [CNT_W-1:0] bubble_d, bubble_q;

    // Count retiring instructions; the popcount is taken modulo the counter width.
    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop = pop + CNT_W'(valid_in[c]);
        end
        retire_d = retire_q;
        bubble_d = bubble_q;
        if (!flush_in) begin
            if (bubble) begin
                bubble_d = bubble_q + CNT_W'(1);
            end else if (advance) begin
                retire_d = retire_q + pop;
            end
        end
    end

    // Wrapping performance counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    assign retire_cnt_out = retire_q;
    assign bubble_cnt_out = bubble_q;
`else
    assign retire_cnt_out = '0;
    assign bubble_cnt_out = '0;
`endif

    // Stall bits owned by other stages are deliberately not observed.
    logic unused_bits;
    assign unused_bits = ^{stall_in, valid_in};

endmodule

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
- Parametrised MEM→WB pipeline register for a multi-issue core; carries NUM_CH independent register-write channels from MEM to WB.
- Handles these pipeline events:
  - stall/bubble control from the central stall vector
  - explicit flush
  - x0-write suppression
  - same-cycle write-after-write resolution between channels
- Optionally counts retired instructions and inserted bubbles for performance analysis.

Parameters:
- NUM_CH, 2, number of write-back channels; channel NUM_CH-1 is the youngest.
- DATA_W, 32, register data width.
- IDX_W, 5, register index width.
- STALL_W, 6, width of the stall vector.
- STAGE, 4, stall-vector bit owned by this stage. Constraint: STAGE <= STALL_W-2; violating it is an elaboration error.
- CNT_W, 32, performance counter width.

Ports:
- clk_in  input  1  rising-edge clock.
- rst_in  input  1  reset; asynchronous, active-low.
- stall_in  input  STALL_W  stall vector; bit STAGE is this stage, bit STAGE+1 is WB.
- flush_in  input  1  squash the contents entering WB.
- valid_in  input  NUM_CH  channel carries a real instruction; used for counting only.
- rdE_in  input  NUM_CH  per-channel write enable.
- rdIdx_in  input  NUM_CH*IDX_W  packed indices; channel c occupies [c*IDX_W +: IDX_W].
- rdData_in  input  NUM_CH*DATA_W  packed data; same packing as rdIdx_in.
- rdE_out  output  NUM_CH  registered write enable.
- rdIdx_out  output  NUM_CH*IDX_W  registered indices.
- rdData_out  output  NUM_CH*DATA_W  registered data.
- retire_cnt_out  output  CNT_W  retired-instruction count.
- bubble_cnt_out  output  CNT_W  bubble-cycle count.

Behaviour:
- Reset: rst_in low clears all outputs to 0 immediately, without waiting for a clock edge. Counters also clear. The first update occurs on the first rising edge after rst_in is high.
- Latency: exactly one cycle from input to output on an advance.
- Per-edge priority:
  1. flush
  2. bubble
  3. advance
  4. hold
- Flush (flush_in=1, independent of stall_in): every channel gets rdE=0, idx=0, data=0. Counters are unchanged.
- Bubble (stall_in[STAGE]=1 and stall_in[STAGE+1]=0): all channels are zeroed as for flush; bubble counter +1.
- Advance (stall_in[STAGE]=0): each channel c is evaluated independently.
  - The channel is masked if rdE_in[c]=0, or rdIdx_in[c]=0, or any younger channel c'>c has rdE_in[c']=1 and rdIdx_in[c']=rdIdx_in[c] with that index nonzero.
  - Masked channel: outputs rdE=0, idx=0, data=0.
  - Unmasked channel: outputs rdE=1 and the input idx and data unchanged.
  - Retire counter += popcount(valid_in). The increment is independent of write masking.
- Hold (stall_in[STAGE]=1 and stall_in[STAGE+1]=1, no flush): all outputs and counters keep their values.
- Counters wrap modulo 2^CNT_W with no saturation. The popcount is zero-extended to CNT_W before addition.
- Bits of stall_in other than STAGE and STAGE+1 are ignored.
- Reset asserted mid-stall or mid-flush: outputs clear at once. No stall state survives reset.

Optional Feature:
- Macro: MEM_WB_PERF_CNT_EN.
- Defined: retire_cnt_out and bubble_cnt_out are implemented as specified.
- Undefined:
  - Both ports remain present and are tied to constant 0.
  - No counter flops are synthesised.
  - The write-back path behaves identically in both builds.

Test Plan:
- Reset/advance:
  - Hold rst_in low, then release.
  - Drive stall_in=0, rdE_in=2'b11, idx {7,3}, data {0xAAAA0001, 0x5555_0002}.
  - Expect all outputs 0 during reset; the next edge yields rdE_out=2'b11, idx {7,3}, data unchanged.
  - Expect retire_cnt_out=2 when valid_in=2'b11.
- Bubble vs hold:
  - Register a valid write, then set stall_in[4]=1 and stall_in[5]=0.
  - Expect outputs zeroed and bubble_cnt_out incremented by 1.
  - Then set stall_in[5:4]=2'b11 for 3 cycles.
  - Expect outputs and both counters frozen.
- WAW resolution:
  - Both channels write idx 9, ch0 data 0x11, ch1 data 0x22.
  - Expect rdE_out=2'b10, ch0 idx/data=0, ch1 idx 9 data 0x22.
- x0 suppression:
  - ch0 writes idx 0 data 0xDEAD, ch1 writes idx 0.
  - Expect rdE_out=0 and all idx/data 0. retire_cnt_out still advances by popcount(valid_in).
- Flush priority:
  - Assert flush_in together with stall_in[4]=1, stall_in[5]=0.
  - Expect outputs zeroed and bubble_cnt_out unchanged.
  - Assert rst_in low mid-cycle and expect an immediate clear without a clock edge.
- Counter wrap:
  - Build with CNT_W=4; advance 9 cycles with valid_in=2'b11.
  - Expect retire_cnt_out=18 mod 16=2.
  - Build without MEM_WB_PERF_CNT_EN and expect both counters constant 0.
